// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply, restoring divide,
// N iterations per operation plus one sign-fix/write-back cycle.
//
// state  | meaning
// IDLE   | waiting for start; MTHI/MTLO writes honoured here
// RUN    | N iterations of the shift-add or restoring-divide step
// FIN    | sign correction, HI/LO write-back, done pulse
module mult_div_unit #(
  parameter int N  = 32,
  parameter int CW = 6
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic [1:0]   op_i,
  input  logic [N-1:0] src_a_i,
  input  logic [N-1:0] src_b_i,
  input  logic         wr_hi_i,
  input  logic         wr_lo_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         div_zero_o,
  output logic [N-1:0] hi_o,
  output logic [N-1:0] lo_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  state_e          state_q;
  logic            div_q;
  logic            neg_lo_q;
  logic            neg_hi_q;
  logic            dz_q;
  logic [CW-1:0]   cnt_q;
  logic [N-1:0]    opnd_q;
  logic [N-1:0]    raw_a_q;
  logic [2*N-1:0]  acc_q;
  logic [N-1:0]    hi_q;
  logic [N-1:0]    lo_q;
  logic            busy_q;
  logic            done_q;
  logic            dz_pulse_q;

  logic [N-1:0]    a_abs;
  logic [N-1:0]    b_abs;
  logic [N:0]      mul_sum;
  logic [2*N-1:0]  mul_next;
  logic [N:0]      rem_sh;
  logic            rem_ge;
  logic [N-1:0]    rem_diff;
  logic [2*N-1:0]  div_next;
  logic [2*N-1:0]  prod_fix;
  logic [N-1:0]    quo_fix;
  logic [N-1:0]    rem_fix;

  // Magnitudes of the operands; -2^(N-1) stays 2^(N-1) as an unsigned value.
  always_comb begin
    a_abs = src_a_i;
    b_abs = src_b_i;
    if (op_i[0] && src_a_i[N-1]) a_abs = -src_a_i;
    if (op_i[0] && src_b_i[N-1]) b_abs = -src_b_i;
  end

  // Multiply step: acc = {partial, multiplier}; add multiplicand into the upper half, shift right.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, opnd_q} : {(N+1){1'b0}});
    mul_next = {mul_sum, acc_q[N-1:1]};
  end

  // Divide step: acc = {rem, quo}; shift left, trial-subtract divisor from the remainder.
  always_comb begin
    rem_sh   = {acc_q[2*N-1:N], acc_q[N-1]};
    rem_ge   = (rem_sh >= {1'b0, opnd_q});
    rem_diff = rem_sh[N-1:0] - opnd_q;
    if (rem_ge) div_next = {rem_diff, acc_q[N-2:0], 1'b1};
    else        div_next = {rem_sh[N-1:0], acc_q[N-2:0], 1'b0};
  end

  always_comb begin
    prod_fix = neg_lo_q ? -acc_q : acc_q;
    quo_fix  = neg_lo_q ? -acc_q[N-1:0] : acc_q[N-1:0];
    rem_fix  = neg_hi_q ? -acc_q[2*N-1:N] : acc_q[2*N-1:N];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      div_q      <= 1'b0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      dz_q       <= 1'b0;
      cnt_q      <= '0;
      opnd_q     <= '0;
      raw_a_q    <= '0;
      acc_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dz_pulse_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      dz_pulse_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            div_q    <= op_i[1];
            neg_lo_q <= op_i[0] & (src_a_i[N-1] ^ src_b_i[N-1]);
            neg_hi_q <= op_i[0] & op_i[1] & src_a_i[N-1];
            dz_q     <= op_i[1] & (src_b_i == '0);
            raw_a_q  <= src_a_i;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_RUN;
            if (op_i[1]) begin
              opnd_q <= b_abs;
              acc_q  <= {{N{1'b0}}, a_abs};
            end else begin
              opnd_q <= a_abs;
              acc_q  <= {{N{1'b0}}, b_abs};
            end
          end else begin
            if (wr_hi_i) hi_q <= src_a_i;
            if (wr_lo_i) lo_q <= src_a_i;
          end
        end
        S_RUN: begin
          acc_q <= div_q ? div_next : mul_next;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(N-1)) state_q <= S_FIN;
        end
        S_FIN: begin
          if (!div_q) begin
            hi_q <= prod_fix[2*N-1:N];
            lo_q <= prod_fix[N-1:0];
          end else if (dz_q) begin
            hi_q <= raw_a_q;
            lo_q <= '1;
          end else begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end
          done_q     <= 1'b1;
          dz_pulse_q <= dz_q;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign div_zero_o = dz_pulse_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus randomized operations
// compared against a plain-arithmetic 64-bit reference model.
module tb_mult_div_unit;
  localparam int N = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [N-1:0] src_a;
  logic [N-1:0] src_b;
  logic         wr_hi;
  logic         wr_lo;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [N-1:0] hi;
  logic [N-1:0] lo;

  int checks;
  int failures;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;
  logic [31:0] corners [6];

  mult_div_unit #(.N(N), .CW(6)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .op_i       (op),
    .src_a_i    (src_a),
    .src_b_i    (src_b),
    .wr_hi_i    (wr_hi),
    .wr_lo_i    (wr_lo),
    .busy_o     (busy),
    .done_o     (done),
    .div_zero_o (div_zero),
    .hi_o       (hi),
    .lo_o       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Reference: MIPS HI/LO semantics from 64-bit integer arithmetic.
  task automatic ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] eh, output logic [31:0] el, output logic edz);
    longint sa;
    longint sb;
    logic [63:0] r;
    sa = o[0] ? longint'($signed(a)) : longint'({32'b0, a});
    sb = o[0] ? longint'($signed(b)) : longint'({32'b0, b});
    edz = 1'b0;
    if (!o[1]) begin
      r  = sa * sb;
      eh = r[63:32];
      el = r[31:0];
    end else if (b == 32'd0) begin
      edz = 1'b1;
      eh  = a;
      el  = 32'hFFFF_FFFF;
    end else begin
      r  = sa / sb;
      el = r[31:0];
      r  = sa % sb;
      eh = r[31:0];
    end
  endtask

  // Caller is at a negedge; inj_* give the post-launch cycle at which a stray Start/WrLo is driven.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int inj_start, input int inj_wr);
    logic [31:0] eh;
    logic [31:0] el;
    logic        edz;
    int          cyc;
    ref_model(o, a, b, eh, el, edz);
    op    = o;
    src_a = a;
    src_b = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wr_hi = 1'b0;
    wr_lo = 1'b0;
    op    = 2'($urandom_range(3));
    src_a = $urandom;
    src_b = $urandom;
    cyc   = 0;
    while (!done && cyc < 200) begin
      if (cyc == N) chk({tag, "_busy_run"}, 64'(busy), 64'd1);
      start = (cyc == inj_start);
      wr_lo = (cyc == inj_wr);
      if (cyc == inj_start) op = 2'($urandom_range(3));
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    wr_lo = 1'b0;
    chk({tag, "_latency"}, 64'(cyc), 64'(N + 1));
    chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    chk({tag, "_hi"}, 64'(hi), 64'(eh));
    chk({tag, "_lo"}, 64'(lo), 64'(el));
    chk({tag, "_divzero"}, 64'(div_zero), 64'(edz));
    exp_hi = eh;
    exp_lo = el;
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'({done, div_zero}), 64'd0);
  endtask

  task automatic mt(input string tag, input logic h, input logic l, input logic [31:0] v);
    wr_hi = h;
    wr_lo = l;
    src_a = v;
    @(negedge clk);
    wr_hi = 1'b0;
    wr_lo = 1'b0;
    src_a = $urandom;
    if (h) exp_hi = v;
    if (l) exp_lo = v;
    chk({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(lo), 64'(exp_lo));
  endtask

  function automatic logic [31:0] pick();
    if ($urandom_range(3) == 0) return corners[$urandom_range(5)];
    return $urandom;
  endfunction

  initial begin
    logic seen_done;
    checks   = 0;
    failures = 0;
    corners  = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};
    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    src_a = '0;
    src_b = '0;
    wr_hi = 1'b0;
    wr_lo = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    repeat (3) @(negedge clk);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_flags", 64'({busy, done, div_zero}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
    chk("multu_max_hi_const", 64'(hi), 64'hFFFF_FFFE);
    run_op("mult_neg3x7", 2'b01, 32'hFFFF_FFFD, 32'd7, -1, -1);
    chk("mult_neg3x7_lo_const", 64'(lo), 64'hFFFF_FFEB);
    run_op("mult_min_sq", 2'b01, 32'h8000_0000, 32'h8000_0000, -1, -1);
    run_op("div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, -1, -1);
    chk("div_m7_2_lo_const", 64'(lo), 64'hFFFF_FFFD);
    run_op("divu_100_7", 2'b10, 32'd100, 32'd7, -1, -1);
    run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
    chk("div_ovf_lo_const", 64'(lo), 64'h8000_0000);
    run_op("divu_zero", 2'b10, 32'h0000_1234, 32'd0, -1, -1);
    run_op("div_zero_neg", 2'b11, 32'hFFFF_FF00, 32'd0, -1, -1);

    run_op("busy_ignore", 2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 5, 10);
    mt("mthi", 1'b1, 1'b0, 32'hCAFE_F00D);
    mt("mthi_mtlo", 1'b1, 1'b1, 32'h5A5A_1234);
    repeat (4) @(negedge clk);
    chk("hold_hi", 64'(hi), 64'(exp_hi));
    chk("hold_lo", 64'(lo), 64'(exp_lo));

    wr_hi = 1'b1;
    wr_lo = 1'b1;
    run_op("start_wins", 2'b10, 32'd1000, 32'd3, -1, -1);

    for (int i = 0; i < 40; i++) begin
      run_op("rand", 2'($urandom_range(3)), pick(), pick(), -1, -1);
      if ($urandom_range(3) == 0)
        mt("rand_mt", 1'($urandom_range(1)), 1'($urandom_range(1)), $urandom);
    end

    mt("pre_rst", 1'b1, 1'b1, 32'h1111_1111);
    op    = 2'b11;
    src_a = 32'hFFFF_FC18;
    src_b = 32'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_hi", 64'(hi), 64'd0);
    chk("rst_mid_lo", 64'(lo), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    exp_hi = '0;
    exp_lo = '0;
    seen_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      seen_done = seen_done | done;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen_done = seen_done | done;
    end
    chk("rst_mid_no_done", 64'(seen_done), 64'd0);
    run_op("post_rst_6x7", 2'b00, 32'd6, 32'd7, -1, -1);
    chk("post_rst_lo_const", 64'(lo), 64'd42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
